// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg
//   Shared types for the convolution forward-pass controller.
//   conv_ctrl_state_t : sequencer state encoding
//   conv_result_t     : result FIFO entry {data, filt, pos}; the index fields
//                       are sized for the largest supported layer and the
//                       controller uses only the low bits it needs.
package cnn_ctrl_pkg;

  localparam int FLOAT_W   = 32;
  localparam int MAX_IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } conv_ctrl_state_t;

  typedef struct packed {
    logic [FLOAT_W-1:0]   data;
    logic [MAX_IDX_W-1:0] filt;
    logic [MAX_IDX_W-1:0] pos;
  } conv_result_t;

endpackage

// File: rtl/conv_result_fifo.sv
// conv_result_fifo
//   Synchronous FIFO of conv_result_t with a registered head entry.
//   Ports:
//     clk, reset        : clock, asynchronous active-low reset
//     push, din         : write strobe and entry (ignored when full unless popping)
//     pop               : consumer takes the head (ignored when empty)
//     head              : registered head entry, held while not popped
//     valid             : FIFO not empty
//     count             : current occupancy
module conv_result_fifo
  import cnn_ctrl_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  conv_result_t     din,
  input  logic             pop,
  output conv_result_t     head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  conv_result_t     mem [DEPTH];
  conv_result_t     head_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] remaining;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (count != '0);
  // A full FIFO can still accept a write in the cycle its head leaves.
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rd_nxt    = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign remaining = count - CNT_W'(do_pop);
  assign count_nxt = remaining + CNT_W'(do_push);
  assign valid     = (count != '0);

  // Next head: the incoming entry if nothing older remains, otherwise the
  // stored entry at the next read pointer; held when the FIFO goes empty.
  always_comb begin
    head_nxt = head;
    if (count_nxt != '0) begin
      if (do_push && (remaining == '0)) head_nxt = din;
      else                              head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/conv_forward_ctrl.sv
// conv_forward_ctrl
//   Walks every (filter, position) pair of a layer in filter-major order,
//   issues one dot-product per cycle into a fixed-latency datapath, tracks
//   in-flight operations with a tag pipe and collects results in a FIFO.
//   Issue is throttled by a credit count (in flight + queued) so a result
//   always finds room in the FIFO.
//   Ports:
//     clk, reset                 : clock, asynchronous active-low reset
//     start / busy / done        : layer-level handshake
//     dp_enable                  : datapath enable for the whole job
//     issue, rd_filt, rd_pos     : buffer read strobe and indices
//     dp_result                  : datapath output, DP_LATENCY after issue
//     out_valid/out_ready        : result stream handshake
//     out_data/out_filt/out_pos  : registered head result
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | issuing operations while credits allow
//   DRAIN  | all issued; waiting for FIFO empty and nothing in flight
//   FINISH | one-cycle done pulse, datapath disabled
module conv_forward_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int NUM_OUT    = 8,
  parameter  int NUM_POS    = 64,
  parameter  int DP_LATENCY = 12,
  parameter  int FIFO_DEPTH = 8,
  localparam int FILT_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int POS_W      = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               dp_enable,
  output logic               issue,
  output logic [FILT_W-1:0]  rd_filt,
  output logic [POS_W-1:0]   rd_pos,
  input  logic [FLOAT_W-1:0] dp_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] out_data,
  output logic [FILT_W-1:0]  out_filt,
  output logic [POS_W-1:0]   out_pos
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  if (WIDTH < 1 || DP_LATENCY < 1 || FIFO_DEPTH < 2 ||
      FILT_W > MAX_IDX_W || POS_W > MAX_IDX_W) begin : g_bad_params
    $error("conv_forward_ctrl: unsupported parameter set");
  end

  conv_ctrl_state_t  state;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] credits_nxt;
  logic              pop;
  logic              room;
  logic              last_op;

  logic              tag_v [DP_LATENCY];
  logic [FILT_W-1:0] tag_f [DP_LATENCY];
  logic [POS_W-1:0]  tag_p [DP_LATENCY];

  conv_result_t      push_entry;
  conv_result_t      head;
  logic [CNT_W-1:0]  fifo_count_unused;
  logic              unused_head_bits;

  assign pop         = out_valid && out_ready;
  assign credits_nxt = credits + CRED_W'(issue) - CRED_W'(pop);
  // issue is registered, so the decision for next cycle uses next credits.
  assign room        = (credits_nxt < CRED_W'(FIFO_DEPTH));
  assign last_op     = (rd_filt == FILT_W'(NUM_OUT - 1)) &&
                       (rd_pos  == POS_W'(NUM_POS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dp_enable <= 1'b0;
      issue     <= 1'b0;
      rd_filt   <= '0;
      rd_pos    <= '0;
      credits   <= '0;
    end else begin
      credits <= credits_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            dp_enable <= 1'b1;
            issue     <= 1'b1;
            rd_filt   <= '0;
            rd_pos    <= '0;
          end
        end
        RUN: begin
          if (issue && last_op) begin
            state   <= DRAIN;
            issue   <= 1'b0;
            rd_filt <= '0;
            rd_pos  <= '0;
          end else begin
            if (issue) begin
              if (rd_pos == POS_W'(NUM_POS - 1)) begin
                rd_pos  <= '0;
                rd_filt <= rd_filt + 1'b1;
              end else begin
                rd_pos <= rd_pos + 1'b1;
              end
            end
            issue <= room;
          end
        end
        DRAIN: begin
          if (credits_nxt == '0) begin
            state     <= FINISH;
            done      <= 1'b1;
            busy      <= 1'b0;
            dp_enable <= 1'b0;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DP_LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_f[i] <= '0;
        tag_p[i] <= '0;
      end
    end else begin
      tag_v[0] <= issue;
      tag_f[0] <= rd_filt;
      tag_p[0] <= rd_pos;
      for (int i = 1; i < DP_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign push_entry.data = dp_result;
  assign push_entry.filt = MAX_IDX_W'(tag_f[DP_LATENCY-1]);
  assign push_entry.pos  = MAX_IDX_W'(tag_p[DP_LATENCY-1]);

  conv_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_v[DP_LATENCY-1]),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .valid (out_valid),
    .count (fifo_count_unused)
  );

  assign out_data = head.data;
  assign out_filt = head.filt[FILT_W-1:0];
  assign out_pos  = head.pos[POS_W-1:0];

  // Upper index bits of the shared entry type are always zero here.
  assign unused_head_bits = ^{head.filt, head.pos};

endmodule
